hazard_tracker: RTL

Pipeline hazard tracker for the five-stage core. Shifts each instruction's destination register, write enable and result-readiness countdown (Tnew) through the E, M and W stages. Compares the D-stage instruction's source registers and their latest safe-use time (Tuse) against that tracked state, and raises `stall` when the D-stage instruction must wait. Its E/M/W destination and write-enable outputs feed the forwarding-select logic directly.

---
 rtl/hazard_tracker.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/hazard_tracker.sv
`default_nettype none
// ============================================================================
// Module   : hazard_tracker
// Purpose  : Five-stage pipeline hazard tracker. Carries destination index,
//            write enable and result-readiness countdown (Tnew) through the
//            E/M/W stages and raises a same-cycle stall when the D-stage
//            instruction reads a register that is not yet forwardable.
// Options  : HAZARD_MDU_STALL_EN - when defined, a mult/div busy countdown is
//            built and D-stage HI/LO users stall while the unit is busy.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_tracker #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_A1,
  input  logic [4:0] D_A2,
  input  logic [1:0] D_Tuse_rs,
  input  logic [1:0] D_Tuse_rt,
  input  logic [4:0] D_A3,
  input  logic       D_RegWrite,
  input  logic [1:0] D_Tnew,
  input  logic       D_MDUse,
  input  logic       E_MDStart,
  input  logic       E_MDIsDiv,
  output logic       stall,
  output logic [4:0] E_A3,
  output logic [4:0] M_A3,
  output logic [4:0] W_A3,
  output logic       E_RegWrite,
  output logic       M_RegWrite,
  output logic       W_RegWrite,
  output logic [1:0] E_Tnew,
  output logic [1:0] M_Tnew,
  output logic       mdu_busy
);

  localparam int         C_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int         C_CNT_W      = $clog2(C_MAX_CYCLES + 1);
  localparam logic [1:0] C_TUSE_NONE  = 2'd3;

  logic [4:0] e_a3_q, e_a3_d, m_a3_q, m_a3_d, w_a3_q, w_a3_d;
  logic       e_regwrite_q, e_regwrite_d, m_regwrite_q, m_regwrite_d;
  logic       w_regwrite_q, w_regwrite_d;
  logic [1:0] e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d;

  logic w_rs_hazard;
  logic w_rt_hazard;
  logic w_mdu_stall;
  logic w_mdu_busy;
  logic w_stall;

  // Source-operand hazards: a producer in E or M whose result is not ready
  // by the time the D-stage instruction needs it. W is always forwardable.
  always_comb begin
    w_rs_hazard = 1'b0;
    w_rt_hazard = 1'b0;
    if (D_A1 != 5'd0 && D_Tuse_rs != C_TUSE_NONE) begin
      if (D_A1 == e_a3_q && e_regwrite_q && e_tnew_q > D_Tuse_rs) w_rs_hazard = 1'b1;
      if (D_A1 == m_a3_q && m_regwrite_q && m_tnew_q > D_Tuse_rs) w_rs_hazard = 1'b1;
    end
    if (D_A2 != 5'd0 && D_Tuse_rt != C_TUSE_NONE) begin
      if (D_A2 == e_a3_q && e_regwrite_q && e_tnew_q > D_Tuse_rt) w_rt_hazard = 1'b1;
      if (D_A2 == m_a3_q && m_regwrite_q && m_tnew_q > D_Tuse_rt) w_rt_hazard = 1'b1;
    end
  end

`ifdef HAZARD_MDU_STALL_EN
  localparam logic [C_CNT_W-1:0] C_MULT_LOAD = C_CNT_W'(MULT_CYCLES);
  localparam logic [C_CNT_W-1:0] C_DIV_LOAD  = C_CNT_W'(DIV_CYCLES);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);

  logic [C_CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;

  // Busy countdown: loads only from idle, so a start while busy is dropped.
  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    if (mdu_cnt_q == '0) begin
      if (E_MDStart) mdu_cnt_d = E_MDIsDiv ? C_DIV_LOAD : C_MULT_LOAD;
    end else begin
      mdu_cnt_d = mdu_cnt_q - C_CNT_ONE;
    end
  end

  // Countdown register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mdu_cnt_q <= '0;
    else       mdu_cnt_q <= mdu_cnt_d;
  end

  assign w_mdu_busy  = (mdu_cnt_q != '0);
  assign w_mdu_stall = D_MDUse && (w_mdu_busy || E_MDStart);
`else
  logic [C_CNT_W-1:0] w_unused_cnt;
  logic               w_unused_mdu;

  assign w_unused_cnt = '0;
  assign w_unused_mdu = D_MDUse ^ E_MDStart ^ E_MDIsDiv ^ (|w_unused_cnt);
  assign w_mdu_busy   = 1'b0;
  assign w_mdu_stall  = 1'b0;
`endif

  assign w_stall = w_rs_hazard || w_rt_hazard || w_mdu_stall;

  // Next stage contents: E takes D or a bubble, M and W always advance.
  always_comb begin
    e_a3_d       = w_stall ? 5'd0 : D_A3;
    e_regwrite_d = w_stall ? 1'b0 : D_RegWrite;
    e_tnew_d     = w_stall ? 2'd0 : D_Tnew;
    m_a3_d       = e_a3_q;
    m_regwrite_d = e_regwrite_q;
    m_tnew_d     = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
    w_a3_d       = m_a3_q;
    w_regwrite_d = m_regwrite_q;
  end

  // Stage registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_a3_q       <= 5'd0;
      e_regwrite_q <= 1'b0;
      e_tnew_q     <= 2'd0;
      m_a3_q       <= 5'd0;
      m_regwrite_q <= 1'b0;
      m_tnew_q     <= 2'd0;
      w_a3_q       <= 5'd0;
      w_regwrite_q <= 1'b0;
    end else begin
      e_a3_q       <= e_a3_d;
      e_regwrite_q <= e_regwrite_d;
      e_tnew_q     <= e_tnew_d;
      m_a3_q       <= m_a3_d;
      m_regwrite_q <= m_regwrite_d;
      m_tnew_q     <= m_tnew_d;
      w_a3_q       <= w_a3_d;
      w_regwrite_q <= w_regwrite_d;
    end
  end

  assign stall      = w_stall;
  assign E_A3       = e_a3_q;
  assign M_A3       = m_a3_q;
  assign W_A3       = w_a3_q;
  assign E_RegWrite = e_regwrite_q;
  assign M_RegWrite = m_regwrite_q;
  assign W_RegWrite = w_regwrite_q;
  assign E_Tnew     = e_tnew_q;
  assign M_Tnew     = m_tnew_q;
  assign mdu_busy   = w_mdu_busy;

endmodule
`default_nettype wire
